// File: rtl/gate_stream_packer_pkg.sv
// Shared definitions for the gate stream packer.
// Gate word layout, LSB first:
//   beats        : beat k at [k*BEAT_WIDTH +: BEAT_WIDTH], beat 0 = first accepted
//   count        : number of valid beats minus one, CW = $clog2(BEATS) bits
//   last (MSB)   : word closes a frame
package gate_stream_packer_pkg;

  function automatic int unsigned gate_width(input int unsigned beat_width,
                                             input int unsigned beats);
    return beats * beat_width + $clog2(beats) + 1;
  endfunction

  function automatic int unsigned count_offset(input int unsigned beat_width,
                                               input int unsigned beats);
    return beats * beat_width;
  endfunction

  function automatic int unsigned last_index(input int unsigned beat_width,
                                             input int unsigned beats);
    return beats * beat_width + $clog2(beats);
  endfunction

  localparam int unsigned DefBeatWidth = 8;
  localparam int unsigned DefBeats     = 4;

  // Field view of a gate word for the default geometry.
  typedef struct packed {
    logic                               last;
    logic [$clog2(DefBeats)-1:0]        count;
    logic [DefBeats*DefBeatWidth-1:0]   beats;
  } gate_word_t;

endpackage

// File: rtl/gate_stream_packer_if.sv
// Stream-in / gate-out signal bundle of the gate stream packer.
//   in_valid, in_data, in_last : byte stream from upstream
//   in_ready                   : beat accepted when in_valid & in_ready
//   gate_open                  : gate source side open
//   gate_write, gate_data      : one-cycle write strobe and word to the gate
// Modport slave is the packer's view, master is the environment driving it.
interface gate_stream_packer_if
  import gate_stream_packer_pkg::*;
#(
  parameter int unsigned BEAT_WIDTH = 8,
  parameter int unsigned BEATS      = 4
) ();
  localparam int unsigned GATE_WIDTH = gate_width(BEAT_WIDTH, BEATS);

  logic                  in_valid;
  logic                  in_ready;
  logic [BEAT_WIDTH-1:0] in_data;
  logic                  in_last;
  logic                  gate_open;
  logic                  gate_write;
  logic [GATE_WIDTH-1:0] gate_data;

  modport slave (
    input  in_valid, in_data, in_last, gate_open,
    output in_ready, gate_write, gate_data
  );

  modport master (
    output in_valid, in_data, in_last, gate_open,
    input  in_ready, gate_write, gate_data
  );
endinterface

// File: rtl/gate_stream_packer_write_ctrl.sv
// Hold register and gate write control.
//   clk_i, rstN_i : clock, synchronous active-low reset
//   load          : move load_data into the hold register this cycle
//   load_data     : assembled word
//   gate_open     : gate source side open
//   hold_free     : hold register can take a word this cycle
//   gate_write    : one-cycle write strobe
//   gate_data     : registered hold word
module gate_stream_packer_write_ctrl #(
  parameter int unsigned GATE_WIDTH = 35
) (
  input  logic                  clk_i,
  input  logic                  rstN_i,
  input  logic                  load,
  input  logic [GATE_WIDTH-1:0] load_data,
  input  logic                  gate_open,
  output logic                  hold_free,
  output logic                  gate_write,
  output logic [GATE_WIDTH-1:0] gate_data
);
  logic                  hold_valid_q;
  logic                  wait_close_q;
  logic [GATE_WIDTH-1:0] hold_data_q;

  // wait_close_q blocks a second write until the gate has been seen closed,
  // so a late-dropping open still yields one write per open period.
  assign gate_write = rstN_i & hold_valid_q & gate_open & ~wait_close_q;
  // A word leaving this cycle frees the slot for a same-cycle refill.
  assign hold_free  = ~hold_valid_q | gate_write;
  assign gate_data  = hold_data_q;

  always_ff @(posedge clk_i) begin
    if (!rstN_i) begin
      hold_valid_q <= 1'b0;
      wait_close_q <= 1'b0;
      hold_data_q  <= '0;
    end else begin
      if (load) begin
        hold_valid_q <= 1'b1;
        hold_data_q  <= load_data;
      end else if (gate_write) begin
        hold_valid_q <= 1'b0;
      end

      if (!gate_open) begin
        wait_close_q <= 1'b0;
      end else if (gate_write) begin
        wait_close_q <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/gate_stream_packer.sv
// Packs a narrow valid/ready beat stream into wide gate words and writes each
// word into the gate source side once per gate-open period.
//   clk_i  : source-domain clock
//   rstN_i : synchronous active-low reset
//   bus    : stream input and gate output (slave view)
// Beat counter and assembly register live here; the hold register and write
// strobe live in the write-control sub-module.
module gate_stream_packer
  import gate_stream_packer_pkg::*;
#(
  parameter int unsigned BEAT_WIDTH = 8,
  parameter int unsigned BEATS      = 4
) (
  input logic                    clk_i,
  input logic                    rstN_i,
  gate_stream_packer_if.slave    bus
);
  localparam int unsigned CW          = $clog2(BEATS);
  localparam int unsigned GATE_WIDTH  = gate_width(BEAT_WIDTH, BEATS);
  localparam int unsigned CountOffset = count_offset(BEAT_WIDTH, BEATS);
  localparam int unsigned LastIndex   = last_index(BEAT_WIDTH, BEATS);
  localparam logic [CW-1:0] LastSlot  = CW'(BEATS - 1);

  logic [CW-1:0]         beat_cnt_q;
  logic                  asm_full_q;
  logic [GATE_WIDTH-1:0] asm_data_q;

  logic accept;
  logic word_done;
  logic transfer;
  logic hold_free;

  assign bus.in_ready = rstN_i & ~asm_full_q;
  assign accept       = bus.in_valid & bus.in_ready;
  assign word_done    = (beat_cnt_q == LastSlot) | bus.in_last;
  assign transfer     = asm_full_q & hold_free;

  always_ff @(posedge clk_i) begin
    if (!rstN_i) begin
      beat_cnt_q <= '0;
      asm_full_q <= 1'b0;
      asm_data_q <= '0;
    end else if (transfer) begin
      // Clearing here keeps unfilled slots of the next partial word at zero.
      asm_full_q <= 1'b0;
      asm_data_q <= '0;
    end else if (accept) begin
      asm_data_q[32'(beat_cnt_q) * BEAT_WIDTH +: BEAT_WIDTH] <= bus.in_data;
      if (word_done) begin
        asm_full_q                     <= 1'b1;
        asm_data_q[CountOffset +: CW]  <= beat_cnt_q;
        asm_data_q[LastIndex]          <= bus.in_last;
        beat_cnt_q                     <= '0;
      end else begin
        beat_cnt_q <= beat_cnt_q + CW'(1);
      end
    end
  end

  gate_stream_packer_write_ctrl #(
    .GATE_WIDTH (GATE_WIDTH)
  ) u_write_ctrl (
    .clk_i      (clk_i),
    .rstN_i     (rstN_i),
    .load       (transfer),
    .load_data  (asm_data_q),
    .gate_open  (bus.gate_open),
    .hold_free  (hold_free),
    .gate_write (bus.gate_write),
    .gate_data  (bus.gate_data)
  );
endmodule

// File: tb/tb_gate_stream_packer.sv
module tb_gate_stream_packer;
  import gate_stream_packer_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  gate_stream_packer_if #(.BEAT_WIDTH(8), .BEATS(4)) bus ();

  gate_stream_packer #(
    .BEAT_WIDTH (8),
    .BEATS      (4)
  ) dut (
    .clk_i  (clk),
    .rstN_i (rst_n),
    .bus    (bus)
  );

  typedef struct {
    int          n;
    logic [31:0] beats;
    logic        last;
    gate_word_t  exp;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  // Samples taken at the falling edge of the current cycle.
  logic        s_ready, s_wr, s_acc;
  logic [34:0] s_wdata;

  // Reference packing model and write-order scoreboard.
  int          part_n = 0;
  logic [34:0] part_w = '0;
  logic [34:0] exp_q[$];
  int          wr_cnt = 0;
  logic        closed_since = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mkv(input int n, input logic [31:0] b, input logic l,
                               input gate_word_t e);
    vec_t v;
    v.n = n; v.beats = b; v.last = l; v.exp = e;
    return v;
  endfunction

  // One clock cycle: sample at negedge, run the model, resume 1ns after posedge.
  task automatic cyc();
    logic [34:0] e;
    @(negedge clk);
    s_ready = bus.in_ready;
    s_wr    = bus.gate_write;
    s_wdata = bus.gate_data;
    s_acc   = bus.in_valid & bus.in_ready;
    if (!rst_n) begin
      chk("rst_no_write", {63'd0, s_wr}, 64'd0);
      chk("rst_ready_low", {63'd0, s_ready}, 64'd0);
      part_n = 0; part_w = '0; exp_q.delete(); closed_since = 1'b1;
    end else begin
      if (s_acc) begin
        part_w[part_n*8 +: 8] = bus.in_data;
        if (part_n == 3 || bus.in_last) begin
          part_w[33:32] = 2'(part_n);
          part_w[34]    = bus.in_last;
          exp_q.push_back(part_w);
          part_w = '0; part_n = 0;
        end else begin
          part_n++;
        end
      end
      if (s_wr) begin
        wr_cnt++;
        chk("write_needs_close", {63'd0, closed_since}, 64'd1);
        closed_since = 1'b0;
        if (exp_q.size() == 0) begin
          chk("spurious_write", {63'd0, s_wr}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("write_order", {29'd0, s_wdata}, {29'd0, e});
        end
      end
      if (!bus.gate_open) closed_since = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    int tries = 0;
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_last = l;
    do begin
      cyc();
      tries++;
    end while (!s_acc && tries < 64);
    if (!s_acc) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: beat %h not accepted, expected accept within 64 cycles", d);
    end
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
  endtask

  task automatic wait_write(output int lat);
    lat = 0;
    do begin
      cyc();
      lat++;
    end while (!s_wr && lat < 64);
    if (!s_wr) begin
      n_cmp++; n_err++;
      $display("FAIL write_timeout: no gate write, expected one within 64 cycles");
    end
  endtask

  vec_t vecs[6];
  int   lat, idx, w0;

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.gate_open = 1'b0;

    // Reset state.
    repeat (3) cyc();
    chk("rst_data_zero", {29'd0, s_wdata}, 64'd0);
    rst_n = 1'b1;
    cyc();
    chk("ready_after_rst", {63'd0, s_ready}, 64'd1);
    chk("data_after_rst", {29'd0, s_wdata}, 64'd0);

    // Directed word vectors, gate open, closed for one cycle before each.
    vecs[0] = mkv(4, 32'h44332211, 1'b0, {1'b0, 2'b11, 32'h44332211});
    vecs[1] = mkv(2, 32'h0000BBAA, 1'b1, {1'b1, 2'b01, 32'h0000BBAA});
    vecs[2] = mkv(1, 32'h0000005C, 1'b1, {1'b1, 2'b00, 32'h0000005C});
    vecs[3] = mkv(3, 32'h00030201, 1'b1, {1'b1, 2'b10, 32'h00030201});
    vecs[4] = mkv(4, 32'h0D0C0B0A, 1'b0, {1'b0, 2'b11, 32'h0D0C0B0A});
    vecs[5] = mkv(4, 32'hEFBEADDE, 1'b1, {1'b1, 2'b11, 32'hEFBEADDE});
    for (int i = 0; i < 6; i++) begin
      bus.gate_open = 1'b0;
      cyc();
      bus.gate_open = 1'b1;
      for (int k = 0; k < vecs[i].n; k++)
        send(vecs[i].beats[k*8 +: 8], vecs[i].last && (k == vecs[i].n - 1));
      wait_write(lat);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd2);
      chk($sformatf("vec%0d_data", i), {29'd0, s_wdata}, {29'd0, vecs[i].exp});
    end

    // Last without valid is ignored.
    bus.gate_open = 1'b0; cyc(); bus.gate_open = 1'b1;
    send(8'h77, 1'b0);
    bus.in_last = 1'b1; cyc(); cyc(); bus.in_last = 1'b0;
    send(8'h88, 1'b0); send(8'h99, 1'b0); send(8'hAA, 1'b0);
    wait_write(lat);
    chk("idle_last_ignored", {29'd0, s_wdata}, {29'd0, 3'b011, 32'hAA998877});

    // Gate closed: two words buffered, then backpressure.
    bus.gate_open = 1'b0;
    cyc();
    w0 = wr_cnt;
    idx = 0;
    bus.in_valid = 1'b1; bus.in_data = 8'h10;
    for (int c = 0; c < 40 && idx < 8; c++) begin
      cyc();
      if (s_acc) begin idx++; bus.in_data = 8'(8'h10 + idx); end
    end
    chk("closed_accepted", 64'(idx), 64'd8);
    repeat (3) begin
      cyc();
      chk("closed_ready_low", {63'd0, s_ready}, 64'd0);
    end
    chk("closed_no_write", 64'(wr_cnt - w0), 64'd0);
    bus.gate_open = 1'b1;
    cyc();
    chk("open_write", {63'd0, s_wr}, 64'd1);
    chk("open_word1", {29'd0, s_wdata}, {29'd0, 3'b011, 32'h13121110});
    cyc();
    chk("ready_back", {63'd0, s_ready}, 64'd1);
    if (s_acc) begin idx++; bus.in_data = 8'(8'h10 + idx); end
    // Gate stays open: remaining beats stream but no second write.
    for (int c = 0; c < 8; c++) begin
      cyc();
      if (s_acc) begin idx++; bus.in_data = 8'(8'h10 + idx); end
      if (idx == 12) bus.in_valid = 1'b0;
    end
    chk("all12_accepted", 64'(idx), 64'd12);
    chk("one_write_per_open", 64'(wr_cnt - w0), 64'd1);
    bus.gate_open = 1'b0; cyc(); bus.gate_open = 1'b1;
    wait_write(lat);
    chk("reopen_word2", {29'd0, s_wdata}, {29'd0, 3'b011, 32'h17161514});
    bus.gate_open = 1'b0; cyc(); bus.gate_open = 1'b1;
    wait_write(lat);
    chk("reopen_word3", {29'd0, s_wdata}, {29'd0, 3'b011, 32'h1B1A1918});

    // Reset mid-frame discards the partial word.
    bus.gate_open = 1'b0; cyc(); bus.gate_open = 1'b1;
    w0 = wr_cnt;
    send(8'hE1, 1'b0); send(8'hE2, 1'b0);
    rst_n = 1'b0; cyc();
    rst_n = 1'b1; cyc();
    chk("no_write_after_rst", {63'd0, s_wr}, 64'd0);
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b0);
    wait_write(lat);
    chk("post_rst_word", {29'd0, s_wdata}, {29'd0, 3'b011, 32'h04030201});
    chk("post_rst_writes", 64'(wr_cnt - w0), 64'd1);

    // Random stress against the scoreboard.
    for (int c = 0; c < 10000; c++) begin
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.in_last   = ($urandom_range(0, 5) == 0);
      bus.in_data   = 8'($urandom);
      bus.gate_open = ($urandom_range(0, 3) != 0);
      cyc();
    end
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    for (int c = 0; c < 20; c++) begin bus.gate_open = c[0]; cyc(); end
    if (part_n != 0) send(8'h00, 1'b1);
    for (int c = 0; c < 20; c++) begin bus.gate_open = c[0]; cyc(); end
    chk("stress_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
